datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
- Multi-cycle control FSM for the single-cycle board datapath (instruction memory, register file, ALU, data memory).
- Fetches one instruction per step-button press, or free-runs from a tick divider when the run switch is set.
- Converts level write switches into single-cycle write strobes in the correct phase.
- Owns the instruction address, including beq-style branch redirect from the ALU zero flag.

Parameters:
- PC_W, 3: instruction address width; instruction memory depth is 2**PC_W.
- OFF_W, 3: width of the signed branch offset taken from the immediate.
- RUN_DIV, 50_000_000: clk cycles per free-run instruction tick; must be >= 5.
- CNT_W, 16: width of the retired-instruction counter.
- DEB_CYCLES, 1_000_000: stable cycles required by the debouncer (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- step_btn  in  1  raw asynchronous push-button
- run_sw  in  1  1 = free-run, 0 = single-step
- sw_reg_write  in  1  register-file write intent (level)
- sw_mem_write  in  1  data-memory write intent (level)
- br  in  1  branch enable
- zero  in  1  ALU zero flag, combinational from the datapath
- br_off  in  OFF_W  signed instruction offset, imm[OFF_W-1:0]
- pc  out  PC_W  instruction address to instruction memory
- reg_write  out  1  register-file WE3 strobe
- mem_write  out  1  data-memory WE strobe
- state  out  3  current FSM state, for LEDs
- busy  out  1  high in any state other than IDLE
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (sync, active-high): next edge sets state=IDLE, pc=0, reg_write=0, mem_write=0, busy=0, retired=0, run-tick divider=0, step synchronizer/edge detector cleared. Reset wins over every other input, including mid-instruction; an in-flight write strobe deasserts at that edge.
- step_btn path: two-flop synchronizer followed by a rising-edge detector, producing a 1-cycle `go_step`.
- run_sw path: free-running divider produces a 1-cycle `go_run` every RUN_DIV cycles, only while run_sw=1; divider holds at 0 while run_sw=0.
- Start condition: `go = run_sw ? go_run : go_step`. When run_sw=1, step presses are ignored.
- FSM states: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4. All outputs are registered.
  - IDLE -> FETCH on go; otherwise stay.
  - FETCH -> EXEC. pc is stable; the instruction memory read settles.
  - EXEC -> MEM. ALU result settles; zero and br are sampled into br_taken = br & zero.
  - MEM -> WB. mem_write=1 for exactly this cycle iff sw_mem_write=1, sampled on entry.
  - WB -> IDLE. reg_write=1 for exactly this cycle iff sw_reg_write=1, sampled on entry.
  - On leaving WB: pc <= br_taken ? pc + 1 + sext(br_off) : pc + 1, modulo 2**PC_W. retired increments and saturates at all-ones.
- Latency: 4 cycles from FETCH to return to IDLE; at most 1 instruction per go.
- go while busy=1 is dropped, not queued.
- Negative or oversized offsets wrap modulo 2**PC_W. Example: PC_W=3, pc=1, br_off=-3 gives 1+1-3 = -1, so pc=7.
- pc=2**PC_W-1 with no branch wraps to 0.
- reg_write and mem_write are never high in the same cycle.
- run_sw toggled mid-instruction: the current instruction completes; the new mode applies from IDLE.
- Write switches changed outside the sampling points have no effect on the current instruction.

Optional Feature:
- Macro: STEP_DEBOUNCE_EN.
- Defined: after the synchronizer, the step level must be stable for DEB_CYCLES cycles before the edge detector sees the change. A press shorter than DEB_CYCLES produces no go_step. Counter resets on rst.
- Undefined: no debounce; the edge detector is fed directly from the synchronizer and DEB_CYCLES is unused.

Decomposition:
- Package seq_pkg:
  - typedef enum logic [2:0] seq_state_t {IDLE, FETCH, EXEC, MEM, WB}
  - localparams for the state encodings used on the `state` LEDs
- Sub-module step_conditioner: synchronizer, optional debounce, and rising-edge pulse. Ports: clk, rst, btn_in, pulse_out.

Test Plan:
- Reset with run_sw=0, then one clean step_btn press (sw_reg_write=1, sw_mem_write=0) -> state walks 1,2,3,4,0; reg_write high only in WB for 1 cycle; mem_write stays 0; pc 0→1; retired=1.
- sw_mem_write=1, sw_reg_write=0 -> mem_write high exactly 1 cycle in MEM, reg_write 0; pc increments by 1.
- pc=1, br=1, zero=1, br_off=3'b101 (-3) -> pc becomes 7. Same stimulus with zero=0 -> pc becomes 2.
- Eight steps with no branch -> pc runs 0..7 then returns to 0; retired=8.
- rst asserted during MEM with sw_mem_write=1 -> next edge gives mem_write=0, state=0, pc=0, retired=0; no WB occurs.
- run_sw=1, RUN_DIV=5, with step_btn pressed repeatedly -> exactly one instruction per 5 cycles and step presses ignored. Separately, a step press while busy -> dropped, retired increments only once. With STEP_DEBOUNCE_EN and DEB_CYCLES=4 -> a 3-cycle press gives no instruction, a 6-cycle press gives one.

Source files
------------

// File: rtl/datapath_sequencer_pkg.sv
// Shared state encodings for the datapath sequencer.
// The state values double as the LED pattern on the `state` output.
package seq_pkg;

    localparam logic [2:0] LED_IDLE  = 3'd0;
    localparam logic [2:0] LED_FETCH = 3'd1;
    localparam logic [2:0] LED_EXEC  = 3'd2;
    localparam logic [2:0] LED_MEM   = 3'd3;
    localparam logic [2:0] LED_WB    = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = LED_IDLE,
        FETCH = LED_FETCH,
        EXEC  = LED_EXEC,
        MEM   = LED_MEM,
        WB    = LED_WB
    } seq_state_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Board-facing signal bundle of the sequencer: switches/buttons and datapath
// flags in, instruction address, write strobes and status out.
interface datapath_sequencer_if #(
    parameter int PC_W  = 3,
    parameter int OFF_W = 3,
    parameter int CNT_W = 16
);
    // No valid/ready here: reg_write and mem_write are single-cycle strobes
    // with no backpressure; pc is held stable from FETCH until leaving WB.
    logic             step_btn;
    logic             run_sw;
    logic             sw_reg_write;
    logic             sw_mem_write;
    logic             br;
    logic             zero;
    logic [OFF_W-1:0] br_off;
    logic [PC_W-1:0]  pc;
    logic             reg_write;
    logic             mem_write;
    logic [2:0]       state;
    logic             busy;
    logic [CNT_W-1:0] retired;

    modport master (
        input  step_btn, run_sw, sw_reg_write, sw_mem_write, br, zero, br_off,
        output pc, reg_write, mem_write, state, busy, retired
    );

    modport slave (
        output step_btn, run_sw, sw_reg_write, sw_mem_write, br, zero, br_off,
        input  pc, reg_write, mem_write, state, busy, retired
    );
endinterface

// File: rtl/datapath_sequencer_step_conditioner.sv
// Step button conditioning: two-flop synchronizer, optional debounce
// (STEP_DEBOUNCE_EN), and a registered one-cycle rising-edge pulse.
module step_conditioner #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse_out
);
    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    logic [DEB_W-1:0] deb_cnt;

    // level only follows sync2 after it has disagreed for DEB_CYCLES cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= 1'b0;
            deb_cnt <= '0;
        end else if (sync2 == level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            level   <= sync2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_d   <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            level_d   <= level;
            pulse_out <= level & ~level_d;
        end
    end
endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the board datapath: step/run start, phased
// write strobes, pc with branch redirect. Optional macro: STEP_DEBOUNCE_EN.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W       = 3,
    parameter int OFF_W      = 3,
    parameter int RUN_DIV    = 50_000_000,
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 1_000_000
) (
    input logic clk,
    input logic rst,
    datapath_sequencer_if.master bus
);
    localparam int DIV_W = $clog2(RUN_DIV);

    logic             go_step;
    logic             go_run;
    logic             go;
    logic [DIV_W-1:0] div_cnt;

    seq_state_t       st;
    logic             br_taken;
    logic [PC_W-1:0]  pc_q;
    logic             reg_write_q;
    logic             mem_write_q;
    logic             busy_q;
    logic [CNT_W-1:0] retired_q;
    logic [PC_W-1:0]  off_ext;

    step_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (bus.step_btn),
        .pulse_out (go_step)
    );

    // Divider restarts from zero every time run mode is entered
    always_ff @(posedge clk) begin
        if (rst || !bus.run_sw) begin
            div_cnt <= '0;
            go_run  <= 1'b0;
        end else if (div_cnt == DIV_W'(RUN_DIV - 1)) begin
            div_cnt <= '0;
            go_run  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            go_run  <= 1'b0;
        end
    end

    assign go      = bus.run_sw ? go_run : go_step;
    assign off_ext = PC_W'($signed(bus.br_off));

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            pc_q        <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            retired_q   <= '0;
            br_taken    <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (go) begin
                        st     <= FETCH;
                        busy_q <= 1'b1;
                    end
                end
                FETCH: st <= EXEC;
                EXEC: begin
                    st          <= MEM;
                    br_taken    <= bus.br & bus.zero;
                    mem_write_q <= bus.sw_mem_write;
                end
                MEM: begin
                    st          <= WB;
                    mem_write_q <= 1'b0;
                    reg_write_q <= bus.sw_reg_write;
                end
                WB: begin
                    st          <= IDLE;
                    reg_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                    pc_q        <= pc_q + PC_W'(1) + (br_taken ? off_ext : '0);
                    if (retired_q != '1) retired_q <= retired_q + 1'b1;
                end
                default: begin
                    st     <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.reg_write = reg_write_q;
    assign bus.mem_write = mem_write_q;
    assign bus.state     = st;
    assign bus.busy      = busy_q;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer with a behavioural pc/retired model.
module tb_datapath_sequencer;
    localparam int PC_W  = 3;
    localparam int OFF_W = 3;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    int               pc_m = 0;
    logic [CNT_W-1:0] retired_m = '0;

    datapath_sequencer_if #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) bus ();

    datapath_sequencer #(
        .PC_W(PC_W), .OFF_W(OFF_W), .RUN_DIV(5), .CNT_W(CNT_W), .DEB_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic model_retire(input logic taken, input logic [OFF_W-1:0] off);
        int sx;
        sx = off[OFF_W-1] ? int'(off) - (1 << OFF_W) : int'(off);
        pc_m = (pc_m + 1 + (taken ? sx : 0)) & ((1 << PC_W) - 1);
        if (retired_m != {CNT_W{1'b1}}) retired_m = retired_m + 1'b1;
    endtask

    task automatic check_pc_retired(input string tag);
        checks++;
        if (bus.pc !== PC_W'(pc_m)) begin
            errors++;
            $display("FAIL %s_pc: got %0d expected %0d", tag, bus.pc, pc_m);
        end
        checks++;
        if (bus.retired !== retired_m) begin
            errors++;
            $display("FAIL %s_retired: got %0d expected %0d", tag, bus.retired, retired_m);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.step_btn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pc_m = 0;
        retired_m = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_instr(input logic rs, input logic ms, input logic b,
                            input logic z, input logic [OFF_W-1:0] off);
        bit seen;
        logic [2:0] exp_st;
        seen = 0;
        bus.sw_reg_write = rs;
        bus.sw_mem_write = ms;
        bus.br = b;
        bus.zero = z;
        bus.br_off = off;
        bus.step_btn = 1'b1;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (bus.state == 3'd1) seen = 1;
        end
        bus.step_btn = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fetch_timeout: got no FETCH, expected FETCH within 60 cycles");
            return;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            exp_st = (i < 4) ? 3'(i + 1) : 3'd0;
            checks++;
            if (bus.state !== exp_st) begin
                errors++;
                $display("FAIL seq_state[%0d]: got %0d expected %0d", i, bus.state, exp_st);
            end
            checks++;
            if (bus.reg_write !== (rs && i == 3)) begin
                errors++;
                $display("FAIL reg_write[%0d]: got %b expected %b", i, bus.reg_write, rs && i == 3);
            end
            checks++;
            if (bus.mem_write !== (ms && i == 2)) begin
                errors++;
                $display("FAIL mem_write[%0d]: got %b expected %b", i, bus.mem_write, ms && i == 2);
            end
            checks++;
            if (bus.busy !== (i < 4)) begin
                errors++;
                $display("FAIL busy[%0d]: got %b expected %b", i, bus.busy, i < 4);
            end
        end
        model_retire(b & z, off);
        check_pc_retired("instr");
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.run_sw = 1'b0;
        bus.sw_reg_write = 1'b0;
        bus.sw_mem_write = 1'b0;
        bus.br = 1'b0;
        bus.zero = 1'b0;
        bus.br_off = '0;
        bus.step_btn = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d busy=%b expected 0/0", bus.state, bus.busy);
        end
        checks++;
        if (bus.reg_write !== 1'b0 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b%b expected 00", bus.reg_write, bus.mem_write);
        end
        pc_m = 0;
        retired_m = '0;
        check_pc_retired("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.state !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: got state=%0d expected 0", bus.state);
        end
    endtask

    task automatic test_step_writes();
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_branch();
        do_reset();
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 3'b101);
        checks++;
        if (bus.pc !== 3'd7) begin
            errors++;
            $display("FAIL branch_taken_pc: got %0d expected 7", bus.pc);
        end
        do_reset();
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 3'b101);
        checks++;
        if (bus.pc !== 3'd2) begin
            errors++;
            $display("FAIL branch_not_taken_pc: got %0d expected 2", bus.pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 8; k++) do_instr(1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
        checks++;
        if (bus.pc !== 3'd0 || bus.retired !== 16'd8) begin
            errors++;
            $display("FAIL wrap: got pc=%0d retired=%0d expected 0/8", bus.pc, bus.retired);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++)
            do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)));
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        bus.sw_mem_write = 1'b1;
        bus.sw_reg_write = 1'b1;
        bus.step_btn = 1'b1;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (bus.state == 3'd1) bus.step_btn = 1'b0;
            if (bus.state == 3'd3) seen = 1;
        end
        bus.step_btn = 1'b0;
        checks++;
        if (!seen || bus.mem_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_mem: got seen=%0d mem_write=%b expected 1/1", seen, bus.mem_write);
        end
        rst = 1'b1;
        @(negedge clk);
        pc_m = 0;
        retired_m = '0;
        checks++;
        if (bus.mem_write !== 1'b0 || bus.state !== 3'd0 || bus.reg_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got mem=%b state=%0d reg=%b expected 0/0/0",
                     bus.mem_write, bus.state, bus.reg_write);
        end
        check_pc_retired("mid_reset");
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (bus.state !== 3'd0 || bus.reg_write !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_wb[%0d]: got state=%0d reg=%b expected 0/0", n, bus.state, bus.reg_write);
            end
        end
    endtask

    task automatic test_run_mode();
        int fetch_cyc[$];
        int n_fetch;
        logic [2:0] prev_st;
        prev_st = bus.state;
        bus.sw_reg_write = 1'b0;
        bus.sw_mem_write = 1'b0;
        bus.br = 1'b0;
        bus.run_sw = 1'b1;
        for (int c = 0; c < 130; c++) begin
            bus.step_btn = (c < 115) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == 125) bus.run_sw = 1'b0;
            @(negedge clk);
            if (bus.state == 3'd1 && prev_st != 3'd1) fetch_cyc.push_back(c);
            prev_st = bus.state;
        end
        n_fetch = fetch_cyc.size();
        checks++;
        if (n_fetch < 20) begin
            errors++;
            $display("FAIL run_count: got %0d instructions expected at least 20", n_fetch);
        end
        for (int k = 1; k < n_fetch; k++) begin
            checks++;
            if (fetch_cyc[k] - fetch_cyc[k-1] != 5) begin
                errors++;
                $display("FAIL run_interval[%0d]: got %0d cycles expected 5", k, fetch_cyc[k] - fetch_cyc[k-1]);
            end
        end
        repeat (10) @(negedge clk);
        for (int k = 0; k < n_fetch; k++) model_retire(1'b0, '0);
        checks++;
        if (bus.state !== 3'd0) begin
            errors++;
            $display("FAIL run_drain: got state=%0d expected 0", bus.state);
        end
        check_pc_retired("run");
    endtask

`ifdef STEP_DEBOUNCE_EN
    task automatic test_debounce();
        int n_fetch;
        logic [2:0] prev_st;
        bus.step_btn = 1'b1;
        repeat (3) @(negedge clk);
        bus.step_btn = 1'b0;
        n_fetch = 0;
        prev_st = bus.state;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.state == 3'd1 && prev_st != 3'd1) n_fetch++;
            prev_st = bus.state;
        end
        checks++;
        if (n_fetch != 0) begin
            errors++;
            $display("FAIL deb_short: got %0d instructions expected 0", n_fetch);
        end
        bus.step_btn = 1'b1;
        repeat (6) @(negedge clk);
        bus.step_btn = 1'b0;
        n_fetch = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.state == 3'd1 && prev_st != 3'd1) n_fetch++;
            prev_st = bus.state;
        end
        checks++;
        if (n_fetch != 1) begin
            errors++;
            $display("FAIL deb_long: got %0d instructions expected 1", n_fetch);
        end
        model_retire(1'b0, '0);
        check_pc_retired("deb");
    endtask
`else
    task automatic test_busy_drop();
        int n_fetch;
        logic [2:0] prev_st;
        bus.br = 1'b0;
        prev_st = bus.state;
        n_fetch = 0;
        // second rising edge reaches the FSM while it is in EXEC
        bus.step_btn = 1'b1;
        @(negedge clk);
        bus.step_btn = 1'b0;
        @(negedge clk);
        bus.step_btn = 1'b1;
        @(negedge clk);
        bus.step_btn = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.state == 3'd1 && prev_st != 3'd1) n_fetch++;
            prev_st = bus.state;
        end
        checks++;
        if (n_fetch != 1) begin
            errors++;
            $display("FAIL busy_drop: got %0d instructions expected 1", n_fetch);
        end
        model_retire(1'b0, '0);
        check_pc_retired("busy_drop");
    endtask
`endif

    initial begin
        test_reset();
        test_step_writes();
        test_branch();
        test_wrap();
        test_random();
        test_reset_mid();
        test_run_mode();
`ifdef STEP_DEBOUNCE_EN
        test_debounce();
`else
        test_busy_drop();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
